// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the system bus sequencer.
package sys_bus_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    MEM_WAIT,
    IO_WAIT,
    ERR,
    DONE
  } bus_state_t;

  // Decoded target of an access.
  typedef enum logic [1:0] {
    REG_MEM,
    REG_IO,
    REG_NONE
  } bus_region_t;

  // Read data returned for any failed access.
  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

  // Shared latency / timeout counter width; covers a timeout of 65535.
  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/sys_bus_if.sv
// CPU, memory, MMIO and error-log signals of the system bus sequencer.
interface sys_bus_if;

  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_we;
  logic        io_req;
  logic        io_ack;
  logic [31:0] io_rdata;

  logic        err_valid;
  logic [31:0] err_addr;
  logic        err_clr;

  // View of the sequencer itself.
  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, mem_rdata, io_ack, io_rdata, err_clr,
    output cpu_rdata, cpu_ready, mem_addr, mem_wdata, mem_we, mem_re,
           io_addr, io_wdata, io_we, io_req, err_valid, err_addr
  );

  // View of the surrounding system (CPU, memory, peripherals).
  modport master (
    output cpu_addr, cpu_wdata, cpu_we, mem_rdata, io_ack, io_rdata, err_clr,
    input  cpu_rdata, cpu_ready, mem_addr, mem_wdata, mem_we, mem_re,
           io_addr, io_wdata, io_we, io_req, err_valid, err_addr
  );

endinterface

// File: rtl/sys_bus_decode.sv
// Combinational address decode: target region, alignment and region offset.
module bus_decode
  import sys_bus_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 65536,
  parameter logic [31:0] IO_BASE   = 32'hF000_0000,
  parameter int unsigned IO_BYTES  = 4096
) (
  input  logic [31:0] addr,
  output bus_region_t region,
  output logic        misaligned,
  output logic [31:0] offset
);

  logic [31:0] io_off;

  // Unsigned compare of the rebased address also rejects addresses below IO_BASE.
  assign io_off     = addr - IO_BASE;
  assign misaligned = (addr[1:0] != 2'b00);

  // Memory is based at zero, so its offset is the address itself.
  always_comb begin
    region = REG_NONE;
    offset = 32'h0;
    if (addr < 32'(MEM_BYTES)) begin
      region = REG_MEM;
      offset = addr;
    end else if (io_off < 32'(IO_BYTES)) begin
      region = REG_IO;
      offset = io_off;
    end
  end

endmodule

// File: rtl/sys_bus.sv
// System bus sequencer: decodes CPU accesses to memory, MMIO or unmapped space,
// runs fixed-latency memory cycles and req/ack MMIO handshakes, logs bus errors.
module sys_bus
  import sys_bus_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 65536,
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [31:0] IO_BASE     = 32'hF000_0000,
  parameter int unsigned IO_BYTES    = 4096,
  parameter int unsigned TIMEOUT     = 255
) (
  input logic      clk,
  input logic      reset,
  sys_bus_if.slave bus
);

  localparam logic [CNT_W-1:0] MEM_LAT_CNT  = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  bus_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             ready_q, ready_d;
  logic             mem_re_q, mem_re_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             io_req_q, io_req_d;
  logic             io_we_q, io_we_d;
  logic [31:0]      io_addr_q, io_addr_d;
  logic [31:0]      io_wdata_q, io_wdata_d;
  logic             err_valid_q, err_valid_d;
  logic [31:0]      err_addr_q, err_addr_d;
  logic             err_set;

  bus_region_t region;
  logic        misaligned;
  logic [31:0] offset;

  bus_decode #(
    .MEM_BYTES (MEM_BYTES),
    .IO_BASE   (IO_BASE),
    .IO_BYTES  (IO_BYTES)
  ) u_decode (
    .addr       (bus.cpu_addr),
    .region     (region),
    .misaligned (misaligned),
    .offset     (offset)
  );

  // Next-state logic: access sequencing, strobes and read-data capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    io_req_d    = io_req_q;
    io_we_d     = io_we_q;
    io_addr_d   = io_addr_q;
    io_wdata_d  = io_wdata_q;
    err_set     = 1'b0;

    unique case (state_q)
      IDLE: begin
        addr_d = bus.cpu_addr;
        we_d   = bus.cpu_we;
        if (misaligned) begin
          state_d = ERR;
        end else begin
          unique case (region)
            REG_MEM: begin
              mem_re_d    = ~bus.cpu_we;
              mem_we_d    = bus.cpu_we;
              mem_addr_d  = {2'b00, offset[31:2]};
              mem_wdata_d = bus.cpu_wdata;
              cnt_d       = MEM_LAT_CNT;
              state_d     = MEM_WAIT;
            end
            REG_IO: begin
              io_req_d   = 1'b1;
              io_we_d    = bus.cpu_we;
              io_addr_d  = offset;
              io_wdata_d = bus.cpu_wdata;
              cnt_d      = '0;
              state_d    = IO_WAIT;
            end
            default: state_d = ERR;
          endcase
        end
      end

      // The edge that takes the counter from 1 to 0 is the one at which
      // mem_rdata is valid.
      MEM_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d = '0;
          if (!we_q) begin
            rdata_d = bus.mem_rdata;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      // Ack is checked before the timeout so a late ack still succeeds.
      IO_WAIT: begin
        if (bus.io_ack) begin
          if (!we_q) begin
            rdata_d = bus.io_rdata;
          end
          io_req_d = 1'b0;
          io_we_d  = 1'b0;
          state_d  = DONE;
        end else if (cnt_q >= TIMEOUT_LAST) begin
          io_req_d = 1'b0;
          io_we_d  = 1'b0;
          rdata_d  = BUS_ERR_DATA;
          err_set  = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ERR: begin
        if (!we_q) begin
          rdata_d = BUS_ERR_DATA;
        end
        err_set = 1'b1;
        state_d = DONE;
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign ready_d = (state_d == DONE);

  // Error log: first error wins, but a new error beats a simultaneous clear.
  always_comb begin
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    if (err_set) begin
      err_valid_d = 1'b1;
      if (!err_valid_q || bus.err_clr) begin
        err_addr_d = addr_q;
      end
    end else if (bus.err_clr) begin
      err_valid_d = 1'b0;
    end
  end

  // State and output registers; reset aborts any access immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      io_req_q    <= 1'b0;
      io_we_q     <= 1'b0;
      io_addr_q   <= '0;
      io_wdata_q  <= '0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      io_req_q    <= io_req_d;
      io_we_q     <= io_we_d;
      io_addr_q   <= io_addr_d;
      io_wdata_q  <= io_wdata_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_ready = ready_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.io_addr   = io_addr_q;
  assign bus.io_wdata  = io_wdata_q;
  assign bus.io_we     = io_we_q;
  assign bus.io_req    = io_req_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_addr  = err_addr_q;

endmodule
